// File: rtl/irq_ctrl.sv
// Word-addressed interrupt controller on the system bridge.
// It latches per-source pending bits, applies the mask and global enable, and drives HWInt to CP0.
module irq_ctrl #(
  parameter int         N_SRC    = 6,
  parameter logic [5:0] RST_EDGE = 6'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic [5:0]       hw_int
);

  logic             gie;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] edge_sel;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] irq_q;
  logic [31:0]      count;

  logic [2:0]       addr;
  logic             wr_ctrl, wr_mask, wr_edge, wr_pend, wr_claim, wr_count;
  logic [N_SRC-1:0] set, clr, pending_next, rise;
  logic [31:0]      count_next;
  logic             unused_addr;

  function automatic logic [31:0] popcount(input logic [N_SRC-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < N_SRC; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // Lowest-index active source wins; a zero word means nothing is claimable.
  function automatic logic [31:0] claim_word(input logic [N_SRC-1:0] v);
    logic [31:0] w;
    w = '0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (v[i]) w = {1'b1, 28'd0, 3'(i)};
    return w;
  endfunction

  assign addr        = Addr[4:2];
  assign unused_addr = ^Addr[31:5];

  assign wr_ctrl  = WE && (addr == 3'd0);
  assign wr_mask  = WE && (addr == 3'd1);
  assign wr_edge  = WE && (addr == 3'd2);
  assign wr_pend  = WE && (addr == 3'd3);
  assign wr_claim = WE && (addr == 3'd4);
  assign wr_count = WE && (addr == 3'd5);

  // Set terms are evaluated regardless of MASK and GIE, and they override a same-cycle clear.
  always_comb begin
    set = irq_in & ~(edge_sel & irq_q);
    clr = '0;
    if (wr_pend)
      clr = Din[N_SRC-1:0];
    if (wr_claim && (int'(Din[2:0]) < N_SRC))
      clr = clr | (N_SRC'(1) << Din[2:0]);
    pending_next = (pending & ~clr) | set;
    rise         = pending_next & ~pending;
    count_next   = wr_count ? Din : count + popcount(rise);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gie      <= 1'b0;
      mask     <= '0;
      edge_sel <= RST_EDGE[N_SRC-1:0];
      pending  <= '0;
      irq_q    <= '0;
      count    <= '0;
      hw_int   <= '0;
    end else begin
      if (wr_ctrl) gie      <= Din[0];
      if (wr_mask) mask     <= Din[N_SRC-1:0];
      if (wr_edge) edge_sel <= Din[N_SRC-1:0];
      pending <= pending_next;
      irq_q   <= irq_in;
      count   <= count_next;
      hw_int  <= gie ? 6'(pending_next & mask) : 6'd0;
    end
  end

  always_comb begin
    Dout = '0;
    case (addr)
      3'd0:    Dout = {31'd0, gie};
      3'd1:    Dout = 32'(mask);
      3'd2:    Dout = 32'(edge_sel);
      3'd3:    Dout = 32'(pending);
      3'd4:    Dout = claim_word(pending & mask);
      3'd5:    Dout = count;
      default: Dout = '0;
    endcase
  end

endmodule
